cache_refill: RTL

Line-fill and store-write controller sitting directly upstream of the 8 KB data cache's write port (13-bit byte address, 64-bit data, per-byte write select, one-cycle registered write). On a miss it requests a critical-word-first wrapping burst from the bus and writes each returned beat into the cache. It forwards the critical word to the core and reports completion or error. Between refills it passes core byte-masked stores through to the same write port.

---
 rtl/cache_refill_pkg.sv | 29 ++
 rtl/cache_refill_beat_ctr.sv | 53 +++++
 rtl/cache_refill.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/cache_refill_pkg.sv
// cache_refill_pkg: shared data-cache geometry, refill FSM state encoding and
// cache address slice helpers used by the line-fill controller.
package cache_refill_pkg;

  localparam int unsigned LINE_BYTES = 64;
  localparam int unsigned BEAT_BYTES = 8;
  localparam int unsigned CACHE_AW   = 13;
  localparam int unsigned BEAT_SHIFT = $clog2(BEAT_BYTES);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FILL = 2'd2,
    S_DONE = 2'd3
  } refill_state_e;

  // Cache byte address with the in-line offset (low off_w bits) cleared.
  function automatic logic [CACHE_AW-1:0] line_base(input logic [CACHE_AW-1:0] a,
                                                    input int unsigned         off_w);
    return a & ~((CACHE_AW'(1) << off_w) - CACHE_AW'(1));
  endfunction

  // Byte address of beat 'idx' within the line starting at 'base'.
  function automatic logic [CACHE_AW-1:0] beat_addr(input logic [CACHE_AW-1:0] base,
                                                    input int unsigned         idx);
    return base | CACHE_AW'(idx << BEAT_SHIFT);
  endfunction

endpackage

// File: rtl/cache_refill_beat_ctr.sv
// refill_beat_ctr: wrapping beat index and beat counter for one line refill.
//   init          : load idx from start_idx and clear count (start of refill)
//   start_idx     : critical word index within the line
//   advance       : one beat has been written
//   idx           : line-relative index of the beat to write next
//   count         : beats written so far
//   last_expected : the next beat is the final beat of the line
module refill_beat_ctr #(
  parameter int unsigned LINE_BEATS = 8,
  parameter int unsigned IDX_W      = $clog2(LINE_BEATS),
  parameter int unsigned CNT_W      = IDX_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic [IDX_W-1:0] start_idx,
  input  logic             advance,
  output logic [IDX_W-1:0] idx,
  output logic [CNT_W-1:0] count,
  output logic             last_expected
);

  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    idx_d   = idx_q;
    count_d = count_q;
    if (init) begin
      idx_d   = start_idx;
      count_d = '0;
    end else if (advance) begin
      // LINE_BEATS is a power of two, so natural overflow wraps within the line.
      idx_d   = idx_q + IDX_W'(1);
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      count_q <= '0;
    end else begin
      idx_q   <= idx_d;
      count_q <= count_d;
    end
  end

  assign idx           = idx_q;
  assign count         = count_q;
  assign last_expected = (count_q == CNT_W'(LINE_BEATS - 1));

endmodule

// File: rtl/cache_refill.sv
// cache_refill: line-fill and store-write controller in front of the data
// cache write port. A miss issues a critical-word-first wrapping burst; each
// returned beat is registered into the cache write port, the first beat is
// forwarded to the core, and completion/error is reported on fill_done /
// fill_err. While idle, core byte-masked stores pass to the same write port.
//   miss_req/miss_addr          : refill request (sampled in IDLE only)
//   busy/fill_done/fill_err     : refill status
//   crit_valid/crit_data        : critical word forward
//   bus_req/bus_addr/bus_gnt    : burst read request handshake
//   bus_rvalid/rdata/rlast/rerr : burst read beats
//   st_valid/addr/data/bsel     : core store, accepted when st_ready
//   cw_addr/data/we/bsel        : registered cache write port
module cache_refill
  import cache_refill_pkg::*;
#(
  parameter int unsigned LINE_BEATS = 8,
  parameter int unsigned PA_W       = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                miss_req,
  input  logic [PA_W-1:0]     miss_addr,
  output logic                busy,
  output logic                fill_done,
  output logic                fill_err,
  output logic                crit_valid,
  output logic [63:0]         crit_data,
  output logic                bus_req,
  output logic [PA_W-1:0]     bus_addr,
  input  logic                bus_gnt,
  input  logic                bus_rvalid,
  input  logic [63:0]         bus_rdata,
  input  logic                bus_rlast,
  input  logic                bus_rerr,
  input  logic                st_valid,
  input  logic [CACHE_AW-1:0] st_addr,
  input  logic [63:0]         st_data,
  input  logic [7:0]          st_bsel,
  output logic                st_ready,
  output logic [CACHE_AW-1:0] cw_addr,
  output logic [63:0]         cw_data,
  output logic                cw_we,
  output logic [7:0]          cw_bsel
);

  localparam int unsigned IDX_W = $clog2(LINE_BEATS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned OFF_W = IDX_W + BEAT_SHIFT;

  refill_state_e       state_q, state_d;
  logic [PA_W-1:0]     addr_q, addr_d;
  logic                err_q, err_d;
  logic [CACHE_AW-1:0] cw_addr_q, cw_addr_d;
  logic [63:0]         cw_data_q, cw_data_d;
  logic                cw_we_q, cw_we_d;
  logic [7:0]          cw_bsel_q, cw_bsel_d;
  logic                crit_valid_q, crit_valid_d;
  logic [63:0]         crit_data_q, crit_data_d;

  logic                ctr_init;
  logic                ctr_adv;
  logic [IDX_W-1:0]    beat_idx;
  logic [CNT_W-1:0]    beat_count;
  logic                last_expected;

  refill_beat_ctr #(
    .LINE_BEATS (LINE_BEATS),
    .IDX_W      (IDX_W),
    .CNT_W      (CNT_W)
  ) u_beat_ctr (
    .clk           (clk),
    .rst_n         (rst_n),
    .init          (ctr_init),
    .start_idx     (miss_addr[OFF_W-1:BEAT_SHIFT]),
    .advance       (ctr_adv),
    .idx           (beat_idx),
    .count         (beat_count),
    .last_expected (last_expected)
  );

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    err_d        = err_q;
    cw_we_d      = 1'b0;
    cw_addr_d    = cw_addr_q;
    cw_data_d    = cw_data_q;
    cw_bsel_d    = cw_bsel_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    ctr_init     = 1'b0;
    ctr_adv      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (miss_req) begin
          // The miss wins over a simultaneous store; the store is retried later.
          state_d  = S_REQ;
          addr_d   = miss_addr & ~PA_W'(BEAT_BYTES - 1);
          err_d    = 1'b0;
          ctr_init = 1'b1;
        end else if (st_valid) begin
          cw_we_d   = 1'b1;
          cw_addr_d = st_addr;
          cw_data_d = st_data;
          cw_bsel_d = st_bsel;
        end
      end
      S_REQ: begin
        if (bus_gnt) state_d = S_FILL;
      end
      S_FILL: begin
        if (bus_rvalid) begin
          if (bus_rerr) begin
            // Erroring beat is dropped; the line will be reported invalid.
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            cw_we_d   = 1'b1;
            cw_addr_d = beat_addr(line_base(addr_q[CACHE_AW-1:0], OFF_W), 32'(beat_idx));
            cw_data_d = bus_rdata;
            cw_bsel_d = '1;
            ctr_adv   = 1'b1;
            if (beat_count == '0) begin
              crit_valid_d = 1'b1;
              crit_data_d  = bus_rdata;
            end
            // Final beat must carry rlast; an rlast any earlier is a short burst.
            if (last_expected) begin
              state_d = S_DONE;
              err_d   = ~bus_rlast;
            end else if (bus_rlast) begin
              state_d = S_DONE;
              err_d   = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      err_q        <= 1'b0;
      cw_addr_q    <= '0;
      cw_data_q    <= '0;
      cw_we_q      <= 1'b0;
      cw_bsel_q    <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      cw_addr_q    <= cw_addr_d;
      cw_data_q    <= cw_data_d;
      cw_we_q      <= cw_we_d;
      cw_bsel_q    <= cw_bsel_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  assign busy       = (state_q != S_IDLE);
  assign bus_req    = (state_q == S_REQ);
  assign bus_addr   = addr_q;
  assign fill_done  = (state_q == S_DONE);
  assign fill_err   = fill_done & err_q;
  assign crit_valid = crit_valid_q;
  assign crit_data  = crit_data_q;
  assign cw_addr    = cw_addr_q;
  assign cw_data    = cw_data_q;
  assign cw_we      = cw_we_q;
  assign cw_bsel    = cw_bsel_q;
  // Gated by rst_n so the combinational ready is also low while in reset.
  assign st_ready   = rst_n & (state_q == S_IDLE) & ~miss_req;

endmodule
